// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive definitions: FSM state encodings and frame constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Smallest usable bit period: half of it must still leave a non-zero count.
    localparam int DIV_MIN         = 4;
    localparam int FRAME_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; head data is zero when empty.
// Latency: push visible on rd_dat/level one cycle later; pop advances head next cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign rd_dat  = empty ? '0 : mem[rd_ptr];
    assign level   = count;

    // Storage write; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracked separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO with a valid/ready pop port and sticky error flags.
// Latency: 2-cycle input sync; byte visible the cycle after the mid-stop-bit sample.
// Backpressure: bytes arriving while the FIFO is full (and not popped) are dropped, overrun_o set.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic [DIV_W-1:0]              div_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    output logic                          frame_err_o,
    input  logic                          clr_err_i
);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_s1;
    logic             rx_s2;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] cnt;
    logic             cnt_zero;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             start_go;
    logic             cnt_reload;
    logic             shift_en;
    logic             push;
    logic             frame_err_set;
    logic             overrun_set;
    logic             fifo_full;
    logic             fifo_empty;

    assign div_clamped = (div_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_i;
    assign cnt_zero    = (cnt == '0);

    // Two-flop synchronizer for the asynchronous pad; idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. IDLE is only entered with the line high, so low in IDLE is a falling edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!rx_s2) state_nxt = ST_START;
            ST_START: if (cnt_zero) state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_zero && bit_idx == 3'(FRAME_DATA_BITS - 1)) state_nxt = ST_STOP;
            ST_STOP:  if (cnt_zero) state_nxt = rx_s2 ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s2) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Per-state strobes driving the datapath, FIFO and flags.
    always_comb begin
        start_go      = 1'b0;
        cnt_reload    = 1'b0;
        shift_en      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        unique case (state)
            ST_IDLE:  start_go = ~rx_s2;
            ST_START: cnt_reload = cnt_zero & ~rx_s2;
            ST_DATA: begin
                shift_en   = cnt_zero;
                cnt_reload = cnt_zero;
            end
            ST_STOP: begin
                push          = cnt_zero & rx_s2;
                frame_err_set = cnt_zero & ~rx_s2;
            end
            default: ;
        endcase
    end

    // Bit timing: divisor frozen at frame start, half period to mid start bit, full periods after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_W'(DIV_MIN);
            cnt   <= '0;
        end else if (start_go) begin
            div_q <= div_clamped;
            cnt   <= (div_clamped >> 1) - DIV_W'(1);
        end else if (cnt_reload) begin
            cnt   <= div_q - DIV_W'(1);
        end else if (!cnt_zero && (state == ST_START || state == ST_DATA || state == ST_STOP)) begin
            cnt   <= cnt - DIV_W'(1);
        end
    end

    // LSB-first shift register and bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state == ST_START) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {rx_s2, shreg[7:1]};
        end
    end

    // A full FIFO only drops the byte when nothing is popped in the same cycle.
    assign overrun_set = push & fifo_full & ~ready_i;

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                overrun_o <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_o <= 1'b1;
            end else if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

    uart_rx_fifo_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (shreg),
        .pop    (ready_i),
        .rd_dat (data_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level_o)
    );

    assign valid_o = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frame-level reference model, decoupled pop monitor.
// Latency: model updates at the mid-stop-bit sample cycle implied by 2-flop sync and half-bit offset.
// Backpressure: ready_i from directed pulses or a random generator; model mirrors accept/drop rules.
module tb_uart_rx_fifo;

    localparam int DIV_W = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic [15:0] div_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  level_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic        clr_err_i;

    logic        man_rdy;
    logic        rand_rdy;
    logic        rand_mode;
    bit          rand_run;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          exp_ovr;
    bit          exp_ferr;

    assign ready_i = rand_mode ? rand_rdy : man_rdy;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .div_i       (div_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o),
        .clr_err_i   (clr_err_i)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: every accepted pop must return the model's head byte.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_model_empty", int'(valid_o), 0);
            end else begin
                chk("pop_data", int'(data_o), int'(exp_q.pop_front()));
            end
        end
    end

    // Quiescent comparison of all visible state against the model.
    task automatic check_state(input string nm);
        chk({nm, "_level"}, int'(level_o), exp_q.size());
        chk({nm, "_valid"}, int'(valid_o), (exp_q.size() > 0) ? 1 : 0);
        chk({nm, "_data"},  int'(data_o),  (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
        chk({nm, "_ovr"},   int'(overrun_o),   int'(exp_ovr));
        chk({nm, "_ferr"},  int'(frame_err_o), int'(exp_ferr));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame and returns inside the stop-sample cycle, after updating the model.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        int d;
        d = (div_i < 16'd4) ? 4 : int'(div_i);
        @(posedge clk); #1;
        rx_i = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (d) @(posedge clk);
            #1;
        end
        rx_i = stop_bit;
        repeat (d / 2 + 2) @(posedge clk);
        #3;
        if (stop_bit) begin
            if (exp_q.size() < DEPTH || ready_i) exp_q.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic pop1();
        @(posedge clk); #1;
        man_rdy = 1'b1;
        @(posedge clk); #1;
        man_rdy = 1'b0;
    endtask

    task automatic clear_errors();
        @(posedge clk); #1;
        clr_err_i = 1'b1;
        @(posedge clk); #1;
        clr_err_i = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic drain(input string nm);
        man_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #3;
            if (!valid_o) break;
        end
        chk({nm, "_drained"}, int'(valid_o), 0);
        man_rdy = 1'b0;
    endtask

    // Random backpressure source, active only in the random phase.
    initial begin
        rand_rdy = 1'b0;
        wait (rand_run);
        while (rand_run) begin
            @(posedge clk); #1;
            rand_rdy = ($urandom_range(0, 31) == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rx_i = 1'b1; div_i = 16'd16; man_rdy = 1'b0;
        clr_err_i = 1'b0; rand_mode = 1'b0; rand_run = 1'b0;
        exp_ovr = 1'b0; exp_ferr = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // Single byte: visible exactly one cycle after the stop sample, then popped.
        send_frame(8'h55, 1'b1);
        chk("t1_valid_at_sample", int'(valid_o), 0);
        @(posedge clk); #3;
        chk("t1_valid_next", int'(valid_o), 1);
        chk("t1_data_next", int'(data_o), 8'h55);
        chk("t1_level_next", int'(level_o), 1);
        idle(16);
        pop1();
        #2;
        check_state("t1_after_pop");

        // Short glitch is rejected at the start-bit sample.
        @(posedge clk); #1;
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_i = 1'b1;
        idle(40);
        check_state("t2_glitch");

        // Framing error followed by a held break, then a good byte.
        send_frame(8'hA3, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rx_i = 1'b1;
        idle(32);
        send_frame(8'h3C, 1'b1);
        idle(16);
        check_state("t3_after_break");
        clear_errors();
        #2;
        check_state("t3_cleared");
        pop1();
        #2;
        check_state("t3_popped");

        // Nine bytes into eight slots: last one dropped.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            idle(16);
        end
        check_state("t4_full");
        clear_errors();

        // Pop coinciding with the stop sample while full: byte accepted at tail.
        fork
            send_frame(8'h0A, 1'b1);
            begin
                @(posedge clk);
                repeat (9 * 16 + 16 / 2 + 2) @(posedge clk);
                #1;
                man_rdy = 1'b1;
                @(posedge clk); #1;
                man_rdy = 1'b0;
            end
        join
        idle(16);
        check_state("t5_full_pushpop");
        drain("t5");
        check_state("t5_empty");

        // Reset during data bit 4 flushes everything.
        send_frame(8'h77, 1'b1);
        idle(16);
        @(posedge clk); #1;
        rx_i = 1'b0;
        repeat (16 * 5 + 8) @(posedge clk);
        #1;
        rst = 1'b1;
        rx_i = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        check_state("t6_in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);
        check_state("t6_after_reset");
        send_frame(8'hC7, 1'b1);
        idle(16);
        check_state("t6_c7");
        pop1();

        // Divisor below minimum runs at four clocks per bit.
        div_i = 16'd2;
        idle(4);
        send_frame(8'h96, 1'b1);
        idle(8);
        check_state("t7_div2");
        pop1();

        // Random frames, divisors and backpressure.
        rand_run = 1'b1;
        rand_mode = 1'b1;
        for (int n = 0; n < 24; n++) begin
            div_i = 16'($urandom_range(2, 12));
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            idle(12 + $urandom_range(0, 8));
        end
        rand_run = 1'b0;
        @(posedge clk); #1;
        rand_mode = 1'b0;
        idle(2);
        check_state("rand_end");
        drain("rand");
        check_state("rand_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
